// File: rtl/ahb_lite_sram_slv.sv
// AHB-Lite slave front end for the on-chip SRAM: configurable OKAY wait states,
// two-cycle ERROR for illegal size/alignment, byte-lane writes and read-after-write forwarding.
module ahb_lite_sram_slv #(
    parameter int AW   = 10,
    parameter int WAIT = 0
) (
    input  logic        hclk_i,
    input  logic        hreset_i,
    input  logic        hsel_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic        hready_i,
    input  logic [31:0] hwdata_i,
    output logic [31:0] hrdata_o,
    output logic        hreadyout_o,
    output logic        hresp_o,
    output logic [2:0]  dbg_state_o
);

    // Handshake: an address phase is taken on a rising edge where hsel_i, hready_i and
    // htrans_i[1] are all high; its data phase ends on the first edge with hreadyout_o=1.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAITING = 3'd1,
        S_LAST    = 3'd2,
        S_ERR1    = 3'd3,
        S_ERR2    = 3'd4
    } state_t;

    localparam logic [2:0] WAIT_INIT = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

    state_t        state;
    logic [2:0]    cnt;
    logic [AW-1:0] widx_q;
    logic          write_q;
    logic [3:0]    lanes_q;
    logic [31:0]   mem [2**AW];

    logic          accept;
    logic          illegal;
    logic [3:0]    lanes;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic          unused_ok;

    assign accept      = hsel_i & hready_i & htrans_i[1] & hreadyout_o;
    assign dbg_state_o = state;
    assign unused_ok   = ^{haddr_i[31:AW+2], htrans_i[0]};

    always_comb begin
        illegal = 1'b0;
        lanes   = 4'b0000;
        case (hsize_i)
            3'd0: lanes = 4'b0001 << haddr_i[1:0];
            3'd1: begin
                lanes   = haddr_i[1] ? 4'b1100 : 4'b0011;
                illegal = haddr_i[0];
            end
            3'd2: begin
                lanes   = 4'b1111;
                illegal = |haddr_i[1:0];
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) lanes = 4'b0000;
    end

    // A read captured while a write sits in LAST must see the lanes being written this edge.
    always_comb begin
        rd_idx  = (state == S_WAITING) ? widx_q : haddr_i[AW+1:2];
        rd_word = mem[rd_idx];
        if (state == S_LAST && write_q && widx_q == rd_idx) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_q[i]) rd_word[8*i +: 8] = hwdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            widx_q      <= '0;
            write_q     <= 1'b0;
            lanes_q     <= 4'b0000;
            hreadyout_o <= 1'b1;
            hresp_o     <= 1'b0;
            hrdata_o    <= '0;
        end else begin
            case (state)
                S_WAITING: begin
                    if (cnt == 3'd0) begin
                        state       <= S_LAST;
                        hreadyout_o <= 1'b1;
                        if (!write_q) hrdata_o <= rd_word;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_ERR1: begin
                    state       <= S_ERR2;
                    hreadyout_o <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        widx_q  <= haddr_i[AW+1:2];
                        write_q <= hwrite_i & ~illegal;
                        lanes_q <= lanes;
                        if (illegal) begin
                            state       <= S_ERR1;
                            hreadyout_o <= 1'b0;
                            hresp_o     <= 1'b1;
                        end else if (WAIT == 0) begin
                            state       <= S_LAST;
                            hreadyout_o <= 1'b1;
                            hresp_o     <= 1'b0;
                            if (!hwrite_i) hrdata_o <= rd_word;
                        end else begin
                            state       <= S_WAITING;
                            cnt         <= WAIT_INIT;
                            hreadyout_o <= 1'b0;
                            hresp_o     <= 1'b0;
                        end
                    end else begin
                        state       <= S_IDLE;
                        write_q     <= 1'b0;
                        hreadyout_o <= 1'b1;
                        hresp_o     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage is not reset; the reset guard drops a write whose LAST coincides with reset.
    always_ff @(posedge hclk_i) begin
        if (!hreset_i && state == S_LAST && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_q[i]) mem[widx_q][8*i +: 8] <= hwdata_i[8*i +: 8];
            end
        end
    end

endmodule
